data_break_arbiter: RTL and testbench

//  Data-break (DMA) arbiter and sequencer for the PDP-8/I memory path.

---
 rtl/data_break_arbiter_if.sv | 36 +++
 rtl/data_break_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_break_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_break_arbiter_if.sv
// Data-break bus between the arbiter and the peripheral/memory side.
//   master : arbiter view  (takes requests/handshakes, drives grant/ack/status)
//   slave  : environment view (drives requests/handshakes, observes grant/ack)
// Signals:
//   brk_rq      level break requests, index 0 = highest fixed priority
//   cpu_at_end  CPU at end of its memory cycle, break may be taken
//   mem_done    one-cycle pulse, break memory cycle finished
//   err_clr     clears the sticky timeout flag
//   brk_active  CPU hold
//   mem_start   one-cycle pulse starting the break memory cycle
//   brk_gnt     one-hot grant, valid START..CYCLE
//   brk_ack     one-hot, one-cycle completion pulse
//   timeout_err sticky, mem_done never arrived
interface data_break_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] brk_rq;
  logic            cpu_at_end;
  logic            mem_done;
  logic            err_clr;
  logic            brk_active;
  logic            mem_start;
  logic [NREQ-1:0] brk_gnt;
  logic [NREQ-1:0] brk_ack;
  logic            timeout_err;

  modport master (
    input  brk_rq, cpu_at_end, mem_done, err_clr,
    output brk_active, mem_start, brk_gnt, brk_ack, timeout_err
  );

  modport slave (
    output brk_rq, cpu_at_end, mem_done, err_clr,
    input  brk_active, mem_start, brk_gnt, brk_ack, timeout_err
  );
endinterface

// File: rtl/data_break_arbiter.sv
// Data-break (DMA) arbiter and sequencer for the PDP-8/I memory path.
// Holds the CPU at a memory-cycle boundary, grants one requester per break
// memory cycle, acknowledges it on mem_done and flags a missing mem_done.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_break_arbiter_if.master (requests, handshakes, grant/ack)
// Parameters:
//   NREQ        number of requesters (2..8), index 0 = highest
//   ROUND_ROBIN 0 = fixed priority, 1 = rotating priority
//   TIMEOUT     max cycles spent in CYCLE waiting for mem_done
//   TW          timeout counter width, 2**TW > TIMEOUT
module data_break_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned TIMEOUT     = 63,
  parameter int unsigned TW          = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_break_arbiter_if.master bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CPU,
    ARB,
    START,
    CYCLE,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_next;
  logic [TW-1:0]   count;
  logic [NREQ-1:0] win_mask;

  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            found;
  int unsigned     base;

  assign win_mask = NREQ'(1) << winner;
  assign rr_next  = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

  // Search starts at rr_ptr (rotating) or 0 (fixed) and wraps; first hit wins.
  always_comb begin
    base  = (ROUND_ROBIN != 0) ? 32'(rr_ptr) : 32'd0;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((base + i) % NREQ);
      if (!found && bus.brk_rq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      winner          <= '0;
      rr_ptr          <= '0;
      count           <= '0;
      bus.brk_active  <= 1'b0;
      bus.mem_start   <= 1'b0;
      bus.brk_gnt     <= '0;
      bus.brk_ack     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.mem_start <= 1'b0;
      bus.brk_ack   <= '0;
      // A timeout in CYCLE below overrides this clear in the same cycle.
      if (bus.err_clr) bus.timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.brk_rq) begin
            state          <= WAIT_CPU;
            bus.brk_active <= 1'b1;
          end
        end

        WAIT_CPU: begin
          if (bus.cpu_at_end) state <= ARB;
        end

        ARB: begin
          if (!found) begin
            state          <= IDLE;
            bus.brk_active <= 1'b0;
          end else begin
            winner        <= pick;
            bus.brk_gnt   <= NREQ'(1) << pick;
            bus.mem_start <= 1'b1;
            count         <= '0;
            state         <= START;
          end
        end

        // count holds the number of the CYCLE clock being spent (1..TIMEOUT)
        START: begin
          count <= TW'(1);
          state <= CYCLE;
        end

        CYCLE: begin
          if (bus.mem_done) begin
            bus.brk_gnt <= '0;
            bus.brk_ack <= win_mask;
            state       <= DONE;
          end else if (count == TW'(TIMEOUT)) begin
            bus.timeout_err <= 1'b1;
            bus.brk_gnt     <= '0;
            bus.brk_active  <= 1'b0;
            state           <= IDLE;
          end else begin
            count <= count + TW'(1);
          end
        end

        // The winner's rq is still high during its ack, so it is masked here.
        DONE: begin
          if (ROUND_ROBIN != 0) rr_ptr <= rr_next;
          if (|(bus.brk_rq & ~win_mask)) begin
            state <= ARB;
          end else begin
            state          <= IDLE;
            bus.brk_active <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_break_arbiter.sv
// Testbench for data_break_arbiter: one fixed-priority and one round-robin
// instance, directed scenarios followed by randomized requester traffic
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_data_break_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned TW      = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_break_arbiter_if #(.NREQ(NREQ)) bus_fix ();
  data_break_arbiter_if #(.NREQ(NREQ)) bus_rr ();

  data_break_arbiter #(.NREQ(NREQ), .ROUND_ROBIN(0), .TIMEOUT(TIMEOUT), .TW(TW)) u_fix (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_fix)
  );

  data_break_arbiter #(.NREQ(NREQ), .ROUND_ROBIN(1), .TIMEOUT(TIMEOUT), .TW(TW)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_rr)
  );

  // index 0 = fixed-priority instance, index 1 = round-robin instance
  logic [NREQ-1:0] rq    [2];
  logic            cae   [2];
  logic            done  [2];
  logic            clr   [2];
  logic            act   [2];
  logic            start [2];
  logic            terr  [2];
  logic [NREQ-1:0] gnt   [2];
  logic [NREQ-1:0] ack   [2];

  assign bus_fix.brk_rq     = rq[0];
  assign bus_fix.cpu_at_end = cae[0];
  assign bus_fix.mem_done   = done[0];
  assign bus_fix.err_clr    = clr[0];
  assign act[0]   = bus_fix.brk_active;
  assign start[0] = bus_fix.mem_start;
  assign terr[0]  = bus_fix.timeout_err;
  assign gnt[0]   = bus_fix.brk_gnt;
  assign ack[0]   = bus_fix.brk_ack;

  assign bus_rr.brk_rq     = rq[1];
  assign bus_rr.cpu_at_end = cae[1];
  assign bus_rr.mem_done   = done[1];
  assign bus_rr.err_clr    = clr[1];
  assign act[1]   = bus_rr.brk_active;
  assign start[1] = bus_rr.mem_start;
  assign terr[1]  = bus_rr.timeout_err;
  assign gnt[1]   = bus_rr.brk_gnt;
  assign ack[1]   = bus_rr.brk_ack;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] one;
    one = 1;
    if (i < 0) return '0;
    return one << i;
  endfunction

  // Reference arbitration: rotate the request vector so position p lands at
  // bit 0, then the first set bit (counted from p, wrapping) wins.
  function automatic int arb(input logic [NREQ-1:0] r, input int unsigned p);
    logic [2*NREQ-1:0] both;
    both = {r, r} >> p;
    for (int j = 0; j < NREQ; j++) begin
      if (both[0]) return int'((32'(j) + p) % NREQ);
      both = both >> 1;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      rq[k]   = '0;
      cae[k]  = 1'b0;
      done[k] = 1'b0;
      clr[k]  = 1'b0;
    end
  endtask

  task automatic wait_start(input int k, input string tag, output int unsigned lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = start[k];
    end
    check({tag, "_start"}, 32'(seen), 1);
  endtask

  // Waits for mem_start, checks the grant, answers mem_done on CYCLE clock
  // number 'delay' and checks the ack that follows.
  task automatic serve(input int k, input int unsigned delay, input logic [NREQ-1:0] exp_gnt,
                       input string tag, output int unsigned lat);
    wait_start(k, tag, lat);
    check({tag, "_gnt"}, gnt[k], exp_gnt);
    @(negedge clk);
    check({tag, "_pulse"}, start[k], 0);
    check({tag, "_hold"}, gnt[k], exp_gnt);
    repeat (delay - 1) @(negedge clk);
    done[k] = 1'b1;
    @(negedge clk);
    done[k] = 1'b0;
    check({tag, "_ack"}, ack[k], exp_gnt);
    check({tag, "_gnt_off"}, gnt[k], '0);
  endtask

  // reference-model state for the randomized phase
  int unsigned     ptr      [2];
  int              w        [2];
  logic            inc      [2];
  int unsigned     cyc      [2];
  int unsigned     dly      [2];
  logic            exp_ack  [2];
  logic            exp_to   [2];
  logic            terr_m   [2];
  logic            clr_prev [2];
  logic [NREQ-1:0] last_rq  [2];
  logic [NREQ-1:0] drop_now [2];
  logic [NREQ-1:0] drop_nxt [2];

  initial begin
    int unsigned     lat;
    int unsigned     acks;
    logic [NREQ-1:0] newrq;
    logic [NREQ-1:0] bitm;
    int unsigned     r;

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_act", act[k], 0);
      check("rst_start", start[k], 0);
      check("rst_gnt", gnt[k], 0);
      check("rst_ack", ack[k], 0);
      check("rst_terr", terr[k], 0);
    end
    rst_n = 1'b1;

    // 1: single request, mem_done on the 3rd CYCLE clock
    @(negedge clk);
    rq[0]  = 4'b0100;
    cae[0] = 1'b1;
    serve(0, 3, 4'b0100, "t1", lat);
    check("t1_latency", lat, 3);
    @(negedge clk);
    check("t1_idle", act[0], 0);
    rq[0] = '0;

    // 2: fixed priority, back-to-back second grant
    @(negedge clk);
    rq[0] = 4'b1010;
    serve(0, 1, 4'b0010, "t2a", lat);
    @(negedge clk);
    check("t2_held", act[0], 1);
    rq[0] = 4'b1000;
    serve(0, 1, 4'b1000, "t2b", lat);
    check("t2_b2b_lat", lat, 1);
    @(negedge clk);
    check("t2_idle", act[0], 0);
    rq[0] = '0;

    // 4: CPU not at end of cycle for 10 clocks
    @(negedge clk);
    rq[0]  = 4'b0001;
    cae[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_act", act[0], 1);
      check("t4_nostart", start[0], 0);
    end
    cae[0] = 1'b1;
    serve(0, 2, 4'b0001, "t4", lat);
    check("t4_lat", lat, 2);
    @(negedge clk);
    rq[0] = '0;

    // 5: timeout; timeout racing err_clr; mem_done on the last allowed clock
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      rq[0] = 4'b0010;
      wait_start(0, "t5", lat);
      acks = 0;
      for (int unsigned c = 1; c <= TIMEOUT; c++) begin
        @(negedge clk);
        if (ack[0] != '0) acks++;
      end
      check("t5_terr_before", terr[0], (m == 1) ? 1 : 0);
      check("t5_gnt_last", gnt[0], 4'b0010);
      rq[0] = '0;
      if (m == 1) clr[0] = 1'b1;
      if (m == 2) done[0] = 1'b1;
      @(negedge clk);
      clr[0]  = 1'b0;
      done[0] = 1'b0;
      if (m == 2) begin
        check("t5_done_wins_ack", ack[0], 4'b0010);
        check("t5_done_wins_terr", terr[0], 0);
      end else begin
        check("t5_terr", terr[0], 1);
        check("t5_gnt_off", gnt[0], 0);
        check("t5_act_off", act[0], 0);
        check("t5_no_ack", ack[0], 0);
      end
      check("t5_no_ack_in_cycle", acks, 0);
      if (m == 1) begin
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("t5_clr", terr[0], 0);
      end
    end

    // 3: round robin with all requests held
    @(negedge clk);
    rq[1]  = 4'b1111;
    cae[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve(1, 1, 4'b0001 << (i % 4), "t3", lat);
      check("t3_lat", lat, (i == 0) ? 3 : 2);
    end
    @(negedge clk);
    rq[1] = '0;
    @(negedge clk);
    check("t3_idle", act[1], 0);

    // 6: asynchronous reset in the middle of CYCLE
    @(negedge clk);
    rq[0]  = 4'b0001;
    cae[0] = 1'b1;
    wait_start(0, "t6", lat);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_act", act[0], 0);
    check("t6_gnt", gnt[0], 0);
    check("t6_ack", ack[0], 0);
    check("t6_start", start[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 2, 4'b0001, "t6b", lat);
    check("t6b_lat", lat, 3);
    @(negedge clk);
    rq[0] = '0;

    // randomized traffic on both instances
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 0; w[k] = -1; inc[k] = 1'b0; cyc[k] = 0; dly[k] = 0;
      exp_ack[k] = 1'b0; exp_to[k] = 1'b0; terr_m[k] = 1'b0; clr_prev[k] = 1'b0;
      last_rq[k] = '0; drop_now[k] = '0; drop_nxt[k] = '0;
    end

    for (int unsigned t = 0; t < 4000; t++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("r_excl", 32'(((gnt[k] & ack[k]) == '0) && $onehot0(gnt[k]) && $onehot0(ack[k])), 1);
        if (exp_to[k]) terr_m[k] = 1'b1;
        else if (clr_prev[k]) terr_m[k] = 1'b0;
        check("r_terr", terr[k], terr_m[k]);

        drop_now[k] = drop_nxt[k];
        drop_nxt[k] = '0;
        if (exp_ack[k]) begin
          check("r_ack", ack[k], onehot(w[k]));
          if (k == 1) ptr[k] = (32'(w[k]) + 1) % NREQ;
          drop_nxt[k] = onehot(w[k]);
        end else begin
          check("r_ack0", ack[k], 0);
        end
        if (exp_to[k]) check("r_to_gnt", gnt[k], 0);
        exp_ack[k] = 1'b0;
        exp_to[k]  = 1'b0;

        if (start[k]) begin
          check("r_start_busy", 32'(inc[k]), 0);
          w[k] = arb(last_rq[k], (k == 1) ? ptr[k] : 0);
          check("r_gnt", gnt[k], onehot(w[k]));
          inc[k] = 1'b1;
          cyc[k] = 0;
          r = $urandom_range(0, 9);
          dly[k] = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
          done[k] = 1'b0;
        end else if (inc[k]) begin
          cyc[k]++;
          check("r_hold", gnt[k], onehot(w[k]));
          check("r_act", act[k], 1);
          done[k] = 1'b0;
          if (cyc[k] == dly[k]) begin
            done[k]    = 1'b1;
            exp_ack[k] = 1'b1;
            inc[k]     = 1'b0;
          end else if (cyc[k] == TIMEOUT) begin
            exp_to[k] = 1'b1;
            inc[k]    = 1'b0;
          end
        end else begin
          check("r_gnt0", gnt[k], 0);
          done[k] = ($urandom_range(0, 15) == 0);
        end

        newrq = rq[k] & ~drop_now[k];
        for (int i = 0; i < NREQ; i++) begin
          bitm = onehot(i);
          if ((rq[k] & bitm) == '0 && $urandom_range(0, 7) == 0) newrq = newrq | bitm;
        end
        rq[k]       = newrq;
        last_rq[k]  = newrq;
        cae[k]      = 1'($urandom_range(0, 1));
        clr[k]      = ($urandom_range(0, 31) == 0);
        clr_prev[k] = clr[k];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
